// File: rtl/regfile_dump_streamer.sv
// Walks the register bank watch port over indices 0..NUM_REGS-1 and streams every value as 4 LSB-first bytes.
// Latency: first byte valid 2 cycles after start is sampled; 5 cycles per register when byteReady is held high.
// Backpressure: byteOut/byteValid are held until byteValid&&byteReady; define REGDUMP_FRAME_EN for preamble + XOR checksum framing.
module regfile_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] watchRegister,
  input  logic [31:0]      watchRegisterValue,
  output logic [7:0]       byteOut,
  output logic             byteValid,
  input  logic             byteReady,
  output logic             busy,
  output logic             done
);

`ifdef REGDUMP_FRAME_EN
  typedef enum logic [2:0] {IDLE, SELECT, SEND, DONE, PREAMBLE, CHECKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  // The byte on the wire is always shift_q[7:0]; preamble and checksum bytes are loaded here too.
  logic [31:0]      shift_q, shift_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef REGDUMP_FRAME_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic xfer;
  logic last_reg;

  assign xfer     = vld_q && byteReady;
  assign last_reg = (idx_q == IDX_W'(NUM_REGS - 1));

  assign watchRegister = idx_q;
  assign byteOut       = shift_q[7:0];
  assign byteValid     = vld_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // Next-state and next-output computation for the dump sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef REGDUMP_FRAME_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          idx_d  = '0;
`ifdef REGDUMP_FRAME_EN
          state_d = PREAMBLE;
          shift_d = 32'h0000_00A5;
          cnt_d   = 2'd0;
          vld_d   = 1'b1;
          csum_d  = 8'h00;
`else
          state_d = SELECT;
`endif
        end
      end
`ifdef REGDUMP_FRAME_EN
      PREAMBLE: begin
        if (xfer) begin
          if (cnt_q == 2'd0) begin
            shift_d = 32'h0000_005A;
            cnt_d   = 2'd1;
          end else begin
            shift_d = '0;
            vld_d   = 1'b0;
            state_d = SELECT;
          end
        end
      end
`endif
      SELECT: begin
        // Watch port is combinational, so the value for idx_q is already valid here.
        shift_d = watchRegisterValue;
        cnt_d   = 2'd0;
        vld_d   = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          shift_d = {8'h00, shift_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
`ifdef REGDUMP_FRAME_EN
          csum_d  = csum_q ^ shift_q[7:0];
`endif
          if (cnt_q == 2'd3) begin
            vld_d = 1'b0;
            if (last_reg) begin
`ifdef REGDUMP_FRAME_EN
              state_d = CHECKSUM;
              shift_d = {24'h0, csum_q ^ shift_q[7:0]};
              vld_d   = 1'b1;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = SELECT;
            end
          end
        end
      end
`ifdef REGDUMP_FRAME_EN
      CHECKSUM: begin
        if (xfer) begin
          shift_d = '0;
          vld_d   = 1'b0;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
`endif
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGDUMP_FRAME_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REGDUMP_FRAME_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Directed bench for regfile_dump_streamer: bank model on the watch port, byte sink with scripted readiness.
// Checks reset values, stream contents/order, latency, hold-under-backpressure, start-while-busy, mid-dump reset, live writes.
// Honours REGDUMP_FRAME_EN by shifting expected byte positions and adding the framed stream test.
module tb_regfile_dump_streamer;

`ifdef REGDUMP_FRAME_EN
  localparam int PRE   = 2;
  localparam int EXTRA = 1;
`else
  localparam int PRE   = 0;
  localparam int EXTRA = 0;
`endif
  localparam int NREG     = 32;
  localparam int TOT      = 4 * NREG + PRE + EXTRA;
  localparam int DONE_CYC = 161 + PRE + EXTRA;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  watchRegister;
  logic [31:0] watchRegisterValue;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        byteReady = 1'b1;
  logic        busy;
  logic        done;

  logic [31:0] bank [NREG];
  assign watchRegisterValue = bank[watchRegister];

  regfile_dump_streamer #(.NUM_REGS(NREG), .IDX_W(5)) dut (
    .clock              (clock),
    .reset              (reset),
    .start              (start),
    .watchRegister      (watchRegister),
    .watchRegisterValue (watchRegisterValue),
    .byteOut            (byteOut),
    .byteValid          (byteValid),
    .byteReady          (byteReady),
    .busy               (busy),
    .done               (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q [$];
  int done_cnt;
  int done_cyc;
  int stab_err;
  bit [15:0] rdy_pat = 16'b1001_1010_0011_0110;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_bank();
    for (int i = 0; i < NREG; i++) bank[i] = (i == 2) ? 32'h0000_03FC : 32'h11 * i;
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] x;
    int d;
    x = 8'h00;
    if (PRE != 0 && k == 0) return 8'hA5;
    if (PRE != 0 && k == 1) return 8'h5A;
    if (EXTRA != 0 && k == TOT - 1) begin
      for (int j = 0; j < 4 * NREG; j++) x = x ^ 8'(bank[j / 4] >> (8 * (j % 4)));
      return x;
    end
    d = k - PRE;
    return 8'(bank[d / 4] >> (8 * (d % 4)));
  endfunction

  task automatic check_stream(input string tag);
    int e;
    e = 0;
    for (int k = 0; k < TOT; k++)
      if (k >= got_q.size() || got_q[k] !== exp_byte(k)) e++;
    check_eq({tag, "_len"}, got_q.size(), TOT);
    check_eq({tag, "_bytes_wrong"}, e, 0);
  endtask

  // Pulse start, then watch the sink every negedge; cycle 1 is the first cycle after start is sampled.
  task automatic run_dump(input int ready_mode, input int restart_cyc, input int wr_cyc, input int abort_byte);
    int n;
    bit prev_hold;
    logic [7:0] prev_byte;
    got_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    stab_err  = 0;
    prev_hold = 1'b0;
    prev_byte = 8'h00;
    @(negedge clock);
    start = 1'b1;
    byteReady = 1'b1;
    @(posedge clock);
    n = 1;
    while (n < 2000) begin
      @(negedge clock);
      start = (n == restart_cyc);
      if (n == wr_cyc) bank[31] = 32'hDEAD_BEEF;
      byteReady = (ready_mode != 0) ? rdy_pat[n % 16] : 1'b1;
      if (prev_hold && (!byteValid || byteOut !== prev_byte)) stab_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (byteValid && got_q.size() == abort_byte) begin
        reset = 1'b1;
        break;
      end
      if (byteValid && byteReady) got_q.push_back(byteOut);
      prev_hold = byteValid && !byteReady;
      prev_byte = byteOut;
      if (done_cyc >= 0 && n >= done_cyc + 5) break;
      n++;
    end
    start = 1'b0;
    byteReady = 1'b1;
    if (abort_byte < 0) check_eq("dump_completed", (done_cyc > 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_bank();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_watchRegister", watchRegister, 0);
    check_eq("rst_byteOut", byteOut, 0);
    check_eq("rst_byteValid", byteValid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("idle_ready_no_effect", byteValid, 0);

    // Basic dump, sink always ready.
    run_dump(0, -1, -1, -1);
    check_stream("basic");
    check_eq("basic_reg2_bytes", {got_q[PRE+11], got_q[PRE+10], got_q[PRE+9], got_q[PRE+8]}, 32'h0000_03FC);
    check_eq("basic_reg1_bytes", {got_q[PRE+7], got_q[PRE+6], got_q[PRE+5], got_q[PRE+4]}, 32'h0000_0011);
    check_eq("basic_done_cycle", done_cyc, DONE_CYC);
    check_eq("basic_done_count", done_cnt, 1);
    check_eq("basic_busy_after", busy, 0);
    check_eq("basic_valid_after", byteValid, 0);

    // Sink readiness toggling.
    run_dump(1, -1, -1, -1);
    check_stream("bp");
    check_eq("bp_hold_violations", stab_err, 0);
    check_eq("bp_done_count", done_cnt, 1);

    // start again while busy is ignored.
    run_dump(0, 20, -1, -1);
    check_eq("restart_len", got_q.size(), TOT);
    check_eq("restart_done_count", done_cnt, 1);

    // Reset while the 3rd byte of reg5 is on the wire.
    run_dump(0, -1, -1, PRE + 22);
    @(posedge clock);
    @(negedge clock);
    check_eq("abort_byteValid", byteValid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_watchRegister", watchRegister, 0);
    check_eq("abort_done", done, 0);
    reset = 1'b0;
    run_dump(0, -1, -1, -1);
    check_stream("after_abort");
    check_eq("after_abort_first", got_q[PRE+0], 8'h00);
    check_eq("after_abort_done_count", done_cnt, 1);

    // Bank write to reg31 during the dump, before its SELECT.
    set_bank();
    run_dump(0, -1, 10, -1);
    check_eq("live_write_reg31", {got_q[PRE+127], got_q[PRE+126], got_q[PRE+125], got_q[PRE+124]}, 32'hDEAD_BEEF);
    check_stream("live_write");

`ifdef REGDUMP_FRAME_EN
    // Framed stream with all registers 0x01010101.
    for (int i = 0; i < NREG; i++) bank[i] = 32'h0101_0101;
    run_dump(0, -1, -1, -1);
    check_eq("frame_len", got_q.size(), 131);
    check_eq("frame_preamble", {got_q[0], got_q[1]}, 16'hA55A);
    check_eq("frame_first_data", got_q[2], 8'h01);
    check_eq("frame_last_data", got_q[129], 8'h01);
    check_eq("frame_checksum", got_q[130], 8'h00);
    check_stream("frame");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_streamer.md
Name: regfile_dump_streamer

Overview:
- Debug reader for the register bank's watch port.
- On a start pulse it drives `watchRegister` through indices 0..NUM_REGS-1 and captures each `watchRegisterValue`.
- It serialises the captured values as a little-endian byte stream on a valid/ready handshake.
- The sink is the UART TX byte interface, so a host can dump all architectural registers at run time without halting the core.

Parameters:
- NUM_REGS, 32: number of registers dumped, starting at index 0. Legal range 1..32.
- IDX_W, 5: width of the `watchRegister` index.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a dump; sampled only in IDLE.
- watchRegister  out  IDX_W  index presented to the register bank watch port.
- watchRegisterValue  in  32  combinational read data from the register bank.
- byteOut  out  8  stream data.
- byteValid  out  1  `byteOut` holds a byte to transfer.
- byteReady  in  1  sink accepts; a transfer occurs on a posedge with byteValid&&byteReady.
- busy  out  1  high from the cycle after start is sampled until DONE completes.
- done  out  1  one-cycle pulse at the end of the dump.

Behaviour:
- Reset values: watchRegister=0, byteOut=0, byteValid=0, busy=0, done=0, state=IDLE, idx=0, byte counter=0.
- States: IDLE, SELECT, SEND, DONE.
- IDLE:
  - start=1 sampled → SELECT, idx=0, busy=1.
  - start=0 → stay.
- SELECT:
  - watchRegister=idx.
  - Next edge: capture watchRegisterValue into a 32-bit shift register, byte counter=0, go to SEND.
- SEND:
  - byteValid=1; byteOut = shift[7:0].
  - byteOut is held stable and byteValid stays high until the transfer; byteValid never drops without a transfer.
  - On transfer: shift >>= 8, counter++.
  - After the 4th transfer:
    - if idx==NUM_REGS-1 → DONE;
    - else idx++ → SELECT.
  - byteValid falls the cycle after the 4th transfer.
- DONE: done=1 for exactly one cycle, busy=0 next cycle, then IDLE.
- Latency with byteReady tied high:
  - first byteValid is high in the 2nd cycle after start is sampled;
  - 5 cycles per register (1 SELECT + 4 SEND);
  - NUM_REGS=32 → 160 cycles from SELECT entry to DONE entry.
- Byte order: register 0 first; within a register, LSB first. Stream length is 4*NUM_REGS bytes.
- Snapshot semantics:
  - each register is sampled in its own SELECT cycle;
  - writes to the bank during a dump are visible if they land before that register's SELECT;
  - the dump is not atomic across registers.
- start while busy: ignored, no queuing. start high in the same cycle DONE exits: not sampled; a new dump needs start in IDLE.
- byteReady high outside SEND: no effect.
- reset mid-dump:
  - returns to IDLE with reset values next cycle;
  - a byte in flight is abandoned;
  - no done pulse.
- No back-pressure on the bank side; the watch port is assumed combinational, so a 1-cycle SELECT is sufficient.

Optional Feature:
- Macro: REGDUMP_FRAME_EN.
- When defined:
  - the stream is framed by the preamble bytes 0xA5, 0x5A, sent from a PREAMBLE state entered from IDLE before the first SELECT;
  - after the last data byte, a CHECKSUM state sends one byte: the XOR of all 4*NUM_REGS data bytes (preamble excluded);
  - total 4*NUM_REGS+3 bytes (131 for the default);
  - all bytes obey the same handshake rules;
  - DONE follows the checksum transfer.
- When undefined: raw data bytes only, no extra states or checksum logic.

Test Plan:
- Bank model holds reg0=0, reg2=0x000003FC, regN=0x11*N for the others; byteReady=1; pulse start → 128 bytes.
  - bytes 8..11 = FC,03,00,00;
  - bytes 4..7 = 11,00,00,00;
  - done pulses once at cycle 161 after start is sampled;
  - busy low afterwards.
- byteReady toggling 1-0-0-1 pseudo-randomly → identical byte sequence; byteOut never changes while byteValid=1 and byteReady=0.
- Assert start again at cycle 20 of a dump → ignored: exactly 128 bytes and one done pulse.
- reset asserted during the 3rd byte of reg5 → next cycle byteValid=0, busy=0, watchRegister=0; a new start dumps from reg0 again.
- Bank write reg31=0xDEADBEEF at cycle 10 of the dump → final 4 bytes = EF,BE,AD,DE.
- With REGDUMP_FRAME_EN, all regs = 0x01010101 → A5,5A, then 128×01, then checksum 00 (131 bytes).
